// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// mac_sequencer
//   Sequences a dot-product job onto an external multiply-accumulate unit.
//   A start in IDLE latches the element count. The MAC is then cleared once,
//   and one A/B operand pair is streamed per cycle whenever both sources have
//   data. After the last pair, the final accumulator value is captured and a
//   one-cycle done pulse is raised.
//
// Ports
//   clk, rst_n          clock; asynchronous reset, active HIGH despite the name
//   start, abort, len   job control; len is latched when start is accepted
//   a_valid/a_data      A operand source (FIFO style)
//   b_valid/b_data      B operand source (FIFO style)
//   a_rd_en/b_rd_en     pop strobes back to the A/B sources
//   mac_en/mac_clr      MAC accumulate enable / accumulator clear
//   mac_a/mac_b         MAC operands, forced to zero when mac_en is low
//   mac_cout            MAC accumulator value
//   busy, done          job in flight / one-cycle completion pulse
//   result/result_valid captured dot product and its qualifier
//   dbg_state           current FSM state (IDLE=0 CLEAR=1 RUN=2 DRAIN=3 DONE=4)
//
// Source handshake: x_valid=1 means x_data holds the head element. The
// sequencer pops a source by raising x_rd_en for one cycle while x_valid=1,
// and the element is consumed on that rising edge. The A and B sources are
// always popped together (rd_en only when both valids are high), so the two
// streams can never drift out of step.
// ---------------------------------------------------------------------------
module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_W-1:0]        len,
    input  logic                    a_valid,
    input  logic [DATA_WIDTH-1:0]   a_data,
    input  logic                    b_valid,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic                    a_rd_en,
    output logic                    b_rd_en,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    busy,
    output logic                    done,
    output logic [3*DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_cnt;
    logic [3*DATA_WIDTH-1:0] r_result;
    logic                    r_result_valid;

    logic w_fire;       // one operand pair handed to the MAC this cycle
    logic w_accept;     // start accepted in IDLE
    logic w_cancel;     // abort honoured in CLEAR/RUN/DRAIN
    logic w_capture;    // DRAIN completing normally: sample the accumulator
    logic w_last;       // current fire is the final element of the job

    assign w_last = (r_cnt == r_len - LEN_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle strobes
    always_comb begin
        w_next    = r_state;
        w_fire    = 1'b0;
        w_accept  = 1'b0;
        w_cancel  = 1'b0;
        w_capture = 1'b0;
        mac_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Abort outranks a simultaneous start.
                if (start && !abort) begin
                    w_accept = 1'b1;
                    w_next   = (len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    w_cancel = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    mac_clr = 1'b1;
                    w_next  = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_cancel = 1'b1;
                    w_next   = S_IDLE;
                end else if (a_valid && b_valid) begin
                    w_fire = 1'b1;
                    if (w_last) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_cancel = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                // Abort is deliberately not looked at: the job is complete.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Job bookkeeping and result capture
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_len          <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len          <= len;
                r_cnt          <= '0;
                r_result_valid <= 1'b0;
                if (len == '0) begin
                    r_result <= '0;
                end
            end
            if (w_fire) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (w_cancel) begin
                r_result_valid <= 1'b0;
            end
            if (w_capture) begin
                r_result <= mac_cout;
            end
            // Entering DONE, either from DRAIN or from a zero-length start.
            // This is placed last so it takes precedence over the clear on
            // accept.
            if (w_next == S_DONE && r_state != S_DONE) begin
                r_result_valid <= 1'b1;
            end
        end
    end

    assign mac_en       = w_fire;
    assign a_rd_en      = w_fire;
    assign b_rd_en      = w_fire;
    assign mac_a        = w_fire ? a_data : '0;
    assign mac_b        = w_fire ? b_data : '0;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int RW = 3 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          abort;
  logic [LW-1:0] len;
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          a_rd_en;
  logic          b_rd_en;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [RW-1:0] mac_cout;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          result_valid;
  logic [2:0]    dbg_state;

  mac_sequencer #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout), .busy(busy), .done(done),
    .result(result), .result_valid(result_valid), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int a_q[$];
  int b_q[$];
  int ja[$];
  int jb[$];
  logic [RW-1:0] acc;
  int cyc = 0;
  int pops_a, pops_b, en_cnt, clr_cnt, done_cnt, done_cyc, busy_cnt;
  int stall_src, stall_at, stall_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sources();
    bit gate_a;
    bit gate_b;
    gate_a = 1'b0;
    gate_b = 1'b0;
    if (stall_left > 0 && pops_a == stall_at) begin
      if (stall_src == 1) gate_a = 1'b1;
      else gate_b = 1'b1;
      stall_left--;
    end
    a_valid = (a_q.size() > 0) && !gate_a;
    a_data  = (a_q.size() > 0) ? DW'(a_q[0]) : '0;
    b_valid = (b_q.size() > 0) && !gate_b;
    b_data  = (b_q.size() > 0) ? DW'(b_q[0]) : '0;
  endtask

  // One clock: sample/check at negedge, then update sources and MAC model after posedge.
  task automatic tick();
    logic sa;
    logic sb;
    logic [RW-1:0] acc_n;
    @(negedge clk);
    cyc++;
    chk("clr_en_exclusive", mac_clr & mac_en, 0);
    chk("pops_follow_mac_en", {a_rd_en, b_rd_en}, {mac_en, mac_en});
    chk("mac_a_value", mac_a, mac_en ? a_data : 8'd0);
    chk("mac_b_value", mac_b, mac_en ? b_data : 8'd0);
    chk("fire_needs_both_valid", mac_en & ~(a_valid & b_valid), 0);
    if (a_rd_en) pops_a++;
    if (b_rd_en) pops_b++;
    if (mac_en) en_cnt++;
    if (mac_clr) clr_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mac_clr) acc_n = '0;
    else if (mac_en) acc_n = acc + ({16'b0, mac_a} * {16'b0, mac_b});
    else acc_n = acc;
    sa = a_rd_en;
    sb = b_rd_en;
    @(posedge clk);
    #1;
    acc = acc_n;
    mac_cout = acc;
    if (sa && a_q.size() > 0) void'(a_q.pop_front());
    if (sb && b_q.size() > 0) void'(b_q.pop_front());
    drive_sources();
  endtask

  task automatic clear_counts();
    pops_a = 0; pops_b = 0; en_cnt = 0; clr_cnt = 0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0;
  endtask

  task automatic flush_sources();
    a_q.delete();
    b_q.delete();
    stall_left = 0;
    drive_sources();
  endtask

  // Runs one job from ja/jb and checks it against the arithmetic reference.
  task automatic run_job(input string tag, input int n, input int s_src, input int s_at,
                         input int s_len, input bit mid_start, input bit abort_done);
    int exp_sum;
    int st_cyc;
    int exp_done;
    int stall_d;
    bit pulsed;
    exp_sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_sum += ja[i] * jb[i];
      a_q.push_back(ja[i]);
      b_q.push_back(jb[i]);
    end
    clear_counts();
    stall_src  = s_src;
    stall_at   = s_at;
    stall_left = (s_src == 0) ? 0 : s_len;
    stall_d    = stall_left;
    drive_sources();
    start  = 1'b1;
    len    = LW'(n);
    st_cyc = cyc + 1;
    exp_done = (n == 0) ? st_cyc + 1 : st_cyc + n + 3 + stall_d;
    tick();
    start = 1'b0;
    len = LW'($urandom_range(0, 15));
    pulsed = 1'b0;
    for (int k = 0; k < 100 && done_cnt == 0; k++) begin
      start = mid_start && !pulsed && (pops_a == 1);
      if (start) pulsed = 1'b1;
      abort = abort_done && (cyc + 1 == exp_done);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_result"}, result, exp_sum & 24'hFFFFFF);
    chk({tag, "_result_valid"}, result_valid, 1);
    tick();
    tick();
    chk({tag, "_pops_a"}, pops_a, n);
    chk({tag, "_pops_b"}, pops_b, n);
    chk({tag, "_mac_en_cycles"}, en_cnt, n);
    chk({tag, "_mac_clr_cycles"}, clr_cnt, (n != 0) ? 1 : 0);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_done - st_cyc);
    chk({tag, "_single_done"}, done_cnt, 1);
    chk({tag, "_result_held"}, result, exp_sum & 24'hFFFFFF);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_strobes"}, {mac_en, mac_clr, a_rd_en, b_rd_en}, 4'b0000);
    chk({tag, "_operands"}, {mac_a, mac_b}, 16'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int prev;
    int n;
    int src;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    acc = '0; mac_cout = '0;
    stall_src = 0; stall_at = 0; stall_left = 0;
    clear_counts();
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b0;
    tick();

    // Basic 3-element job
    ja = '{1, 2, 3}; jb = '{4, 5, 6};
    run_job("len3", 3, 0, 0, 0, 1'b0, 1'b0);

    // Zero-length job after a nonzero result
    run_job("len0", 0, 0, 0, 0, 1'b0, 1'b0);

    // Max operands with B stalled for 2 cycles after 2 fires
    ja = '{255, 255, 255, 255}; jb = '{255, 255, 255, 255};
    run_job("stall", 4, 2, 2, 2, 1'b0, 1'b0);

    // Start pulsed while running is ignored
    ja = '{9, 8, 7}; jb = '{1, 2, 3};
    run_job("mid_start", 3, 0, 0, 0, 1'b1, 1'b0);

    // Start together with abort in IDLE: no job
    clear_counts();
    start = 1'b1; abort = 1'b1; len = 4'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("start_abort_busy", busy, 0);
    chk("start_abort_busy_cycles", busy_cnt, 0);
    chk("start_abort_clr", clr_cnt, 0);

    // Abort after 2 fires of a 5-element job
    prev = int'(result);
    for (int i = 0; i < 5; i++) begin
      a_q.push_back(i + 11);
      b_q.push_back(i + 3);
    end
    clear_counts();
    drive_sources();
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && pops_a < 2; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_next", busy, 0);
    tick();
    chk("abort_pops_a", pops_a, 2);
    chk("abort_pops_b", pops_b, 2);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_result_valid", result_valid, 0);
    chk("abort_result_kept", result, prev);
    flush_sources();
    ja = '{7}; jb = '{9};
    run_job("after_abort", 1, 0, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a 4-element job
    for (int i = 0; i < 4; i++) begin
      a_q.push_back(i + 1);
      b_q.push_back(2);
    end
    clear_counts();
    drive_sources();
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && pops_a < 2; k++) tick();
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b1;
    #1 check_reset_outputs("async_reset");
    tick();
    tick();
    check_reset_outputs("reset_held");
    rst_n = 1'b0;
    flush_sources();
    tick();
    ja = '{10, 20}; jb = '{3, 4};
    run_job("post_reset", 2, 0, 0, 0, 1'b0, 1'b0);

    // Randomized jobs; one exercises abort during DONE
    for (int j = 0; j < 10; j++) begin
      n = $urandom_range(1, 15);
      ja.delete(); jb.delete();
      for (int i = 0; i < n; i++) begin
        ja.push_back($urandom_range(0, 255));
        jb.push_back($urandom_range(0, 255));
      end
      src = (n >= 2) ? $urandom_range(0, 2) : 0;
      run_job($sformatf("rand%0d", j), n, src, (n >= 2) ? $urandom_range(1, n - 1) : 0,
              $urandom_range(1, 3), 1'b0, (j == 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
